// File: rtl/mrd_wrbk_ctrl.sv
// mrd_wrbk_ctrl: butterfly write-back stage.
// Buffers the per-lane bank index/address tags coming from the read sequencer
// in a first-word-fall-through FIFO. Each butterfly result is re-paired with the
// oldest tag and scattered into 7 interleaved RAM banks. Pulses wr_end with the
// final write of a stage.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           begins or restarts a stage; beats_target is sampled with it
//   tag_*           read-side beat: 5 lanes of {bank index (7 = unused), bank addr}
//   res_*           butterfly result beat: 5 lanes of real/imag data
//   wren/wraddr/wrdata_*  per-bank write port, registered
//   wr_end, busy    end-of-stage pulse, stage-active flag
//   err_ovf/unf/coll  sticky errors, cleared by start
module mrd_wrbk_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 18,
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [11:0]                  beats_target,
  input  logic                         tag_valid,
  input  logic [4:0][2:0]              tag_index,
  input  logic [4:0][ADDR_W-1:0]       tag_addr,
  input  logic                         res_valid,
  input  logic [4:0][DATA_W-1:0]       res_real,
  input  logic [4:0][DATA_W-1:0]       res_imag,
  output logic [6:0]                   wren,
  output logic [6:0][ADDR_W-1:0]       wraddr,
  output logic [6:0][DATA_W-1:0]       wrdata_real,
  output logic [6:0][DATA_W-1:0]       wrdata_imag,
  output logic                         wr_end,
  output logic                         busy,
  output logic                         err_ovf,
  output logic                         err_unf,
  output logic                         err_coll
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [11:0]               cnt_q, cnt_d, tgt_q, tgt_d;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]                wren_q, wren_d;
  logic [6:0][ADDR_W-1:0]    wraddr_q, wraddr_d;
  logic [6:0][DATA_W-1:0]    wdr_q, wdr_d, wdi_q, wdi_d;
  logic                      wr_end_q, wr_end_d, busy_q, busy_d;
  logic                      ovf_q, ovf_d, unf_q, unf_d, coll_q, coll_d;

  logic [4:0][2:0]           mem_idx_q  [TAG_DEPTH];
  logic [4:0][ADDR_W-1:0]    mem_addr_q [TAG_DEPTH];
  logic [4:0][2:0]           head_idx;
  logic [4:0][ADDR_W-1:0]    head_addr;
  logic                      empty, full, push, pop, last;
  logic [6:0]                hit;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_idx  = mem_idx_q[rd_ptr_q[PW-1:0]];
  assign head_addr = mem_addr_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wren_d   = '0;
    wraddr_d = wraddr_q;
    wdr_d    = wdr_q;
    wdi_d    = wdi_q;
    wr_end_d = 1'b0;
    busy_d   = (state_q == WRITE);
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    coll_d   = coll_q;
    push     = 1'b0;
    pop      = 1'b0;
    last     = 1'b0;
    hit      = '0;

    if (start) begin
      // Start (or restart) wins over any tag/result beat in the same cycle.
      tgt_d    = beats_target;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      coll_d   = 1'b0;
      if (beats_target == 12'd0) begin
        wr_end_d = 1'b1;
        state_d  = IDLE;
      end else begin
        state_d  = WRITE;
      end
    end else if (state_q == WRITE) begin
      pop  = res_valid && !empty;
      last = pop && ((cnt_q + 12'd1) == tgt_q);
      // A pop frees a slot in the same cycle, so push at full is legal then.
      // On the final beat the stage is over and the tag is discarded.
      push = tag_valid && (!full || pop) && !last;
      if (tag_valid && full && !pop) ovf_d = 1'b1;
      if (res_valid && empty)        unf_d = 1'b1;

      if (pop) begin
        cnt_d = cnt_q + 12'd1;
        for (int k = 0; k < 7; k++) begin
          for (int j = 0; j < 5; j++) begin
            if (!hit[k] && head_idx[j] == 3'(k)) begin
              hit[k]      = 1'b1;
              wren_d[k]   = 1'b1;
              wraddr_d[k] = head_addr[j];
              wdr_d[k]    = res_real[j];
              wdi_d[k]    = res_imag[j];
            end
          end
        end
        for (int i = 0; i < 4; i++)
          for (int j = i + 1; j < 5; j++)
            if (head_idx[i] != 3'd7 && head_idx[i] == head_idx[j]) coll_d = 1'b1;
        if (last) begin
          wr_end_d = 1'b1;
          state_d  = IDLE;
        end
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wren_q   <= '0;
      wraddr_q <= '0;
      wdr_q    <= '0;
      wdi_q    <= '0;
      wr_end_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wdr_q    <= wdr_d;
      wdi_q    <= wdi_d;
      wr_end_q <= wr_end_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      coll_q   <= coll_d;
    end
  end

  // Tag storage needs no reset: the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx_q[wr_ptr_q[PW-1:0]]  <= tag_index;
      mem_addr_q[wr_ptr_q[PW-1:0]] <= tag_addr;
    end
  end

  assign wren        = wren_q;
  assign wraddr      = wraddr_q;
  assign wrdata_real = wdr_q;
  assign wrdata_imag = wdi_q;
  assign wr_end      = wr_end_q;
  assign busy        = busy_q;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign err_coll    = coll_q;

endmodule

// File: tb/tb_mrd_wrbk_ctrl.sv
// Bench for mrd_wrbk_ctrl: directed scenarios plus a random phase, each cycle
// compared against a queue-based transaction model of the write-back rules.
module tb_mrd_wrbk_ctrl;

  logic                  clk = 1'b0;
  logic                  rst, start, tag_valid, res_valid;
  logic [11:0]           beats_target;
  logic [4:0][2:0]       tag_index;
  logic [4:0][7:0]       tag_addr;
  logic [4:0][17:0]      res_real, res_imag;
  logic [6:0]            wren;
  logic [6:0][7:0]       wraddr;
  logic [6:0][17:0]      wrdata_real, wrdata_imag;
  logic                  wr_end, busy, err_ovf, err_unf, err_coll;

  mrd_wrbk_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .beats_target(beats_target),
    .tag_valid(tag_valid), .tag_index(tag_index), .tag_addr(tag_addr),
    .res_valid(res_valid), .res_real(res_real), .res_imag(res_imag),
    .wren(wren), .wraddr(wraddr), .wrdata_real(wrdata_real), .wrdata_imag(wrdata_imag),
    .wr_end(wr_end), .busy(busy), .err_ovf(err_ovf), .err_unf(err_unf), .err_coll(err_coll)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][2:0] idx;
    logic [4:0][7:0] addr;
  } tag_t;

  // Reference model state
  tag_t              q[$];
  bit                in_wr;
  int                m_cnt, m_tgt;
  logic [6:0]        e_wren;
  logic [6:0][7:0]   e_wraddr;
  logic [6:0][17:0]  e_wdr, e_wdi;
  logic              e_end, e_busy, e_ovf, e_unf, e_coll;

  int checks = 0;
  int errors = 0;
  int ends   = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_wr = 0; m_cnt = 0; m_tgt = 0;
    e_wren = '0; e_wraddr = '0; e_wdr = '0; e_wdi = '0;
    e_end = 0; e_busy = 0; e_ovf = 0; e_unf = 0; e_coll = 0;
  endtask

  // One clock edge of the stage rules, driven by the inputs the bench applied.
  task automatic model_edge();
    bit   popped, last, was_full;
    tag_t t;
    int   nb[7];
    e_busy = in_wr;
    e_wren = '0;
    e_end  = 0;
    if (start) begin
      q.delete();
      m_cnt = 0; m_tgt = int'(beats_target);
      e_ovf = 0; e_unf = 0; e_coll = 0;
      if (beats_target == 0) begin e_end = 1; in_wr = 0; end
      else in_wr = 1;
    end else if (in_wr) begin
      popped = 0; last = 0;
      was_full = (q.size() == 16);
      if (res_valid) begin
        if (q.size() == 0) e_unf = 1;
        else begin
          t = q.pop_front();
          popped = 1;
          m_cnt++;
          foreach (nb[k]) nb[k] = 0;
          for (int j = 0; j < 5; j++) if (t.idx[j] != 7) nb[t.idx[j]]++;
          foreach (nb[k]) if (nb[k] > 1) e_coll = 1;
          for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 5; j++) begin
              if (int'(t.idx[j]) == k) begin
                e_wren[k] = 1; e_wraddr[k] = t.addr[j];
                e_wdr[k] = res_real[j]; e_wdi[k] = res_imag[j];
                break;
              end
            end
          end
          if (m_cnt == m_tgt) begin last = 1; e_end = 1; in_wr = 0; end
        end
      end
      if (tag_valid && !last) begin
        if (was_full && !popped) e_ovf = 1;
        else begin
          t.idx = tag_index; t.addr = tag_addr;
          q.push_back(t);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("wren", 128'(wren), 128'(e_wren));
    chk("wraddr", 128'(wraddr), 128'(e_wraddr));
    chk("wrdata_real", 128'(wrdata_real), 128'(e_wdr));
    chk("wrdata_imag", 128'(wrdata_imag), 128'(e_wdi));
    chk("wr_end", 128'(wr_end), 128'(e_end));
    chk("busy", 128'(busy), 128'(e_busy));
    chk("err_ovf", 128'(err_ovf), 128'(e_ovf));
    chk("err_unf", 128'(err_unf), 128'(e_unf));
    chk("err_coll", 128'(err_coll), 128'(e_coll));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (wr_end === 1'b1) ends++;
  endtask

  task automatic do_start(int bt);
    start = 1; beats_target = 12'(bt); tag_valid = 0; res_valid = 0;
    tick();
    start = 0;
  endtask

  task automatic rnd_tag();
    for (int j = 0; j < 5; j++) begin
      tag_index[j] = 3'($urandom_range(0, 7));
      tag_addr[j]  = 8'($urandom);
    end
  endtask

  task automatic rnd_res();
    for (int j = 0; j < 5; j++) begin
      res_real[j] = 18'($urandom);
      res_imag[j] = 18'($urandom);
    end
  endtask

  task automatic push_tag();
    tag_valid = 1; tick(); tag_valid = 0;
  endtask

  task automatic push_res();
    rnd_res(); res_valid = 1; tick(); res_valid = 0;
  endtask

  initial begin
    int a;
    rst = 1; start = 0; beats_target = '0; tag_valid = 0; res_valid = 0;
    tag_index = '0; tag_addr = '0; res_real = '0; res_imag = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 0;
    tick();

    // Nominal radix-5, 4 beats
    do_start(4);
    a = $urandom_range(0, 200);
    for (int b = 0; b < 4; b++) begin
      tag_index = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      for (int j = 0; j < 5; j++) tag_addr[j] = 8'(a + j + b);
      push_tag();
    end
    repeat (2) tick();
    for (int b = 0; b < 4; b++) begin
      push_res();
      chk("nom_wren", 128'(wren), 128'(7'b0011111));
    end
    chk("nom_end", 128'(wr_end), 128'(1));
    chk("nom_busy_last", 128'(busy), 128'(1));
    tick();
    chk("nom_busy_drop", 128'(busy), 128'(0));

    // Radix-2 lanes
    do_start(1);
    tag_index = {3'd7, 3'd7, 3'd7, 3'd6, 3'd5};
    tag_addr  = {8'h00, 8'h00, 8'h00, 8'h66, 8'h55};
    push_tag();
    push_res();
    chk("r2_wren", 128'(wren), 128'(7'b1100000));
    chk("r2_coll", 128'(err_coll), 128'(0));
    chk("r2_addr6", 128'(wraddr[6]), 128'(8'h66));

    // Collision
    do_start(1);
    tag_index = {3'd7, 3'd7, 3'd1, 3'd3, 3'd3};
    tag_addr  = {8'h00, 8'h00, 8'h11, 8'h44, 8'h33};
    push_tag();
    res_real = '0; res_imag = '0;
    res_real[0] = 18'h100; res_real[1] = 18'h200;
    res_valid = 1; tick(); res_valid = 0;
    chk("coll_wren", 128'(wren), 128'(7'b0001010));
    chk("coll_addr3", 128'(wraddr[3]), 128'(8'h33));
    chk("coll_data3", 128'(wrdata_real[3]), 128'(18'h100));
    chk("coll_flag", 128'(err_coll), 128'(1));
    repeat (3) tick();
    chk("coll_sticky", 128'(err_coll), 128'(1));

    // FIFO overflow
    do_start(100);
    chk("start_clr_coll", 128'(err_coll), 128'(0));
    for (int i = 0; i < 16; i++) begin rnd_tag(); push_tag(); end
    chk("ovf_none", 128'(err_ovf), 128'(0));
    rnd_tag(); push_tag();
    chk("ovf_set", 128'(err_ovf), 128'(1));
    // Underrun
    do_start(100);
    push_res();
    chk("unf_set", 128'(err_unf), 128'(1));
    chk("unf_wren", 128'(wren), 128'(0));
    // Simultaneous push/pop at full
    do_start(100);
    for (int i = 0; i < 16; i++) begin rnd_tag(); push_tag(); end
    rnd_tag(); rnd_res(); tag_valid = 1; res_valid = 1; tick(); tag_valid = 0; res_valid = 0;
    chk("full_pp_ovf", 128'(err_ovf), 128'(0));
    chk("full_pp_unf", 128'(err_unf), 128'(0));
    for (int i = 0; i < 16; i++) push_res();
    chk("full_drain_unf", 128'(err_unf), 128'(0));

    // Restart mid-stage
    do_start(8);
    for (int i = 0; i < 2; i++) begin rnd_tag(); push_tag(); end
    push_res(); push_res();
    rnd_tag(); tag_valid = 1; do_start(8);
    ends = 0;
    rnd_tag(); push_tag();
    for (int i = 0; i < 7; i++) begin
      rnd_tag(); rnd_res(); tag_valid = 1; res_valid = 1; tick();
    end
    tag_valid = 0; res_valid = 0;
    push_res();
    chk("restart_ends", 128'(ends), 128'(1));
    chk("restart_unf", 128'(err_unf), 128'(0));

    // beats_target = 0
    do_start(0);
    chk("zero_end", 128'(wr_end), 128'(1));
    chk("zero_busy", 128'(busy), 128'(0));
    tick();
    chk("zero_busy2", 128'(busy), 128'(0));

    // Random phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) do_start($urandom_range(0, 14));
      else begin
        rnd_tag(); rnd_res();
        tag_valid = ($urandom_range(0, 2) != 0);
        res_valid = ($urandom_range(0, 2) == 0);
        tick();
        tag_valid = 0; res_valid = 0;
      end
    end

    // Async reset mid-stage
    do_start(8);
    tag_index = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tag_addr  = {8'h5, 8'h4, 8'h3, 8'h2, 8'h1};
    push_tag();
    push_res();
    chk("pre_rst_busy", 128'(busy), 128'(1));
    chk("pre_rst_wren", 128'(wren), 128'(7'b0011111));
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    chk("rst_async_wren", 128'(wren), 128'(0));
    @(posedge clk);
    #1 rst = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
